// File: rtl/pulse_pacer.sv
// Re-emits accepted event pulses spaced at least MIN_GAP clocks apart, ahead of a toggle
// pulse synchronizer. Define PULSE_PACER_TOGGLE_OUT_EN to add toggle_o (flips per emission).
module pulse_pacer #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned MIN_GAP = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             pulse_i,
  input  logic             enable_i,
  input  logic             clr_ovf_i,
  output logic             pulse_o,
  output logic [CNT_W-1:0] pending_o,
  output logic             busy_o,
  output logic             overflow_o
`ifdef PULSE_PACER_TOGGLE_OUT_EN
  ,
  output logic             toggle_o
`endif
);

  typedef enum logic [1:0] {StIdle, StEmit, StGap} state_e;

  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [7:0]       GapLoad = 8'(MIN_GAP - 2);

  state_e           state_q, state_d;
  logic [7:0]       gap_q, gap_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pulse_q, busy_q;
  logic             ovf_q, ovf_d;
  logic             launch, inc, dec, drop;

  assign launch = enable_i && ((pend_q != '0) || pulse_i);

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    case (state_q)
      StIdle: begin
        if (launch) state_d = StEmit;
      end
      StEmit: begin
        gap_d   = GapLoad;
        state_d = StGap;
      end
      StGap: begin
        if (gap_q == '0) begin
          state_d = launch ? StEmit : StIdle;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A launch from an empty counter consumes the incoming pulse directly, so inc and dec cancel.
  assign dec  = (state_d == StEmit);
  assign drop = pulse_i && (pend_q == CntMax) && !dec;
  assign inc  = pulse_i && !drop;

  always_comb begin
    pend_d = pend_q;
    if (inc && !dec) begin
      pend_d = pend_q + CntOne;
    end else if (dec && !inc) begin
      pend_d = pend_q - CntOne;
    end
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf_i) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
      gap_q   <= '0;
      pend_q  <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      pend_q  <= pend_d;
      pulse_q <= dec;
      busy_q  <= (state_d != StIdle);
      ovf_q   <= ovf_d;
    end
  end

`ifdef PULSE_PACER_TOGGLE_OUT_EN
  logic toggle_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      toggle_q <= 1'b0;
    end else if (dec) begin
      toggle_q <= ~toggle_q;
    end
  end

  assign toggle_o = toggle_q;
`endif

  assign pulse_o    = pulse_q;
  assign pending_o  = pend_q;
  assign busy_o     = busy_q;
  assign overflow_o = ovf_q;

endmodule
